// File: rtl/mmio_arbiter_if.sv
// mmio_arbiter_if: bundles the two master request/grant channels, the
// shared read-data/busy status and the peripheral-side signals of the
// LED/switch MMIO arbiter.
//   slave  modport - the arbiter's view (takes requests, drives the port)
//   master modport - the masters'/peripheral's view (opposite directions)
interface mmio_arbiter_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic              m0_re;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_done;

  logic              m1_req;
  logic              m1_we;
  logic              m1_re;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_done;

  logic [DATA_W-1:0] rdata;
  logic              busy;

  logic              p_writeEnable;
  logic              p_readEnable;
  logic [ADDR_W-1:0] p_memAddress;
  logic [DATA_W-1:0] p_writeData;
  logic [DATA_W-1:0] p_readData;

  modport slave (
    input  m0_req, m0_we, m0_re, m0_addr, m0_wdata,
    output m0_gnt, m0_done,
    input  m1_req, m1_we, m1_re, m1_addr, m1_wdata,
    output m1_gnt, m1_done,
    output rdata, busy,
    output p_writeEnable, p_readEnable, p_memAddress, p_writeData,
    input  p_readData
  );

  modport master (
    output m0_req, m0_we, m0_re, m0_addr, m0_wdata,
    input  m0_gnt, m0_done,
    output m1_req, m1_we, m1_re, m1_addr, m1_wdata,
    input  m1_gnt, m1_done,
    input  rdata, busy,
    input  p_writeEnable, p_readEnable, p_memAddress, p_writeData,
    output p_readData
  );
endinterface

// File: rtl/mmio_arbiter.sv
// mmio_arbiter: two-master arbiter for the memory-mapped peripheral port of
// the LED/switch block. M0 is the CPU load/store path, M1 the countdown FSM /
// debug path. One master is granted per transaction; each transaction runs
// IDLE -> ISSUE -> RESP -> IDLE with every output registered.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - mmio_arbiter_if.slave: m0_*/m1_* request channels, rdata, busy,
//          p_* peripheral signals (p_readData valid 1 cycle after p_readEnable)
module mmio_arbiter #(
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic           clk,
  input  logic           rst,
  mmio_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic              rr_last_r, rr_last_s;   // 0 = M0 granted last, 1 = M1
  logic              owner_r, owner_s;       // master owning the transaction
  logic              rd_op_r, rd_op_s;       // transaction is a read
  logic              m0_gnt_r, m0_gnt_s;
  logic              m1_gnt_r, m1_gnt_s;
  logic              m0_done_r, m0_done_s;
  logic              m1_done_r, m1_done_s;
  logic [DATA_W-1:0] rdata_r, rdata_s;
  logic              busy_r, busy_s;
  logic              we_r, we_s;
  logic              re_r, re_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [DATA_W-1:0] wdata_r, wdata_s;
  logic              win_s;                  // arbitration winner in IDLE
  logic              sel_we_s;
  logic              sel_re_s;

  // Arbitration: fixed priority favours M0; round-robin breaks ties against rr_last.
  always_comb begin
    win_s = 1'b0;
    if (FIXED_PRIO != 32'sd0) begin
      win_s = ~bus.m0_req;
    end else if (bus.m0_req && bus.m1_req) begin
      win_s = ~rr_last_r;
    end else begin
      win_s = ~bus.m0_req;
    end
  end

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    state_s   = state_r;
    rr_last_s = rr_last_r;
    owner_s   = owner_r;
    rd_op_s   = rd_op_r;
    m0_gnt_s  = 1'b0;
    m1_gnt_s  = 1'b0;
    m0_done_s = 1'b0;
    m1_done_s = 1'b0;
    rdata_s   = rdata_r;
    we_s      = 1'b0;
    re_s      = 1'b0;
    addr_s    = addr_r;
    wdata_s   = wdata_r;
    sel_we_s  = 1'b0;
    sel_re_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          state_s   = ST_ISSUE;
          rr_last_s = win_s;
          owner_s   = win_s;
          if (win_s == 1'b0) begin
            m0_gnt_s = 1'b1;
            sel_we_s = bus.m0_we;
            sel_re_s = bus.m0_re;
            addr_s   = bus.m0_addr;
            wdata_s  = bus.m0_wdata;
          end else begin
            m1_gnt_s = 1'b1;
            sel_we_s = bus.m1_we;
            sel_re_s = bus.m1_re;
            addr_s   = bus.m1_addr;
            wdata_s  = bus.m1_wdata;
          end
          // A write wins when both we and re are set.
          we_s    = sel_we_s;
          re_s    = sel_re_s & ~sel_we_s;
          rd_op_s = sel_re_s & ~sel_we_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_s = ST_RESP;
      end
      ST_RESP: begin
        state_s = ST_IDLE;
        if (owner_r == 1'b0) begin
          m0_done_s = 1'b1;
        end else begin
          m1_done_s = 1'b1;
        end
        // Peripheral data is valid during RESP; capture it as we leave.
        if (rd_op_r) begin
          rdata_s = bus.p_readData;
        end else begin
          rdata_s = rdata_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers; reset aborts any transaction without a done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      rr_last_r <= 1'b1;
      owner_r   <= 1'b0;
      rd_op_r   <= 1'b0;
      m0_gnt_r  <= 1'b0;
      m1_gnt_r  <= 1'b0;
      m0_done_r <= 1'b0;
      m1_done_r <= 1'b0;
      rdata_r   <= {DATA_W{1'b0}};
      busy_r    <= 1'b0;
      we_r      <= 1'b0;
      re_r      <= 1'b0;
      addr_r    <= {ADDR_W{1'b0}};
      wdata_r   <= {DATA_W{1'b0}};
    end else begin
      state_r   <= state_s;
      rr_last_r <= rr_last_s;
      owner_r   <= owner_s;
      rd_op_r   <= rd_op_s;
      m0_gnt_r  <= m0_gnt_s;
      m1_gnt_r  <= m1_gnt_s;
      m0_done_r <= m0_done_s;
      m1_done_r <= m1_done_s;
      rdata_r   <= rdata_s;
      busy_r    <= busy_s;
      we_r      <= we_s;
      re_r      <= re_s;
      addr_r    <= addr_s;
      wdata_r   <= wdata_s;
    end
  end

  assign bus.m0_gnt        = m0_gnt_r;
  assign bus.m1_gnt        = m1_gnt_r;
  assign bus.m0_done       = m0_done_r;
  assign bus.m1_done       = m1_done_r;
  assign bus.rdata         = rdata_r;
  assign bus.busy          = busy_r;
  assign bus.p_writeEnable = we_r;
  assign bus.p_readEnable  = re_r;
  assign bus.p_memAddress  = addr_r;
  assign bus.p_writeData   = wdata_r;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed bench for mmio_arbiter: a round-robin instance (ifa) and a
// fixed-priority instance (ifb), each with a registered peripheral model.
module tb_mmio_arbiter;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  mmio_arbiter_if #(.ADDR_W(30), .DATA_W(32)) ifa ();
  mmio_arbiter_if #(.ADDR_W(30), .DATA_W(32)) ifb ();

  mmio_arbiter #(.ADDR_W(30), .DATA_W(32), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst), .bus(ifa.slave));
  mmio_arbiter #(.ADDR_W(30), .DATA_W(32), .FIXED_PRIO(1)) u_fx (
    .clk(clk), .rst(rst), .bus(ifb.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Peripheral read data for a given address.
  function automatic logic [31:0] periph_resp(input logic [29:0] a);
    if (a == 30'h10) return 32'h0000_00A5;
    else return {a, 2'b00} ^ 32'h5A5A_0000;
  endfunction

  // Peripheral models: registered 1-cycle read latency.
  always @(posedge clk) begin
    if (ifa.p_readEnable) ifa.p_readData <= periph_resp(ifa.p_memAddress);
    if (ifb.p_readEnable) ifb.p_readData <= periph_resp(ifb.p_memAddress);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifa.m0_req = 1'b0; ifa.m0_we = 1'b0; ifa.m0_re = 1'b0; ifa.m0_addr = 30'h0; ifa.m0_wdata = 32'h0;
    ifa.m1_req = 1'b0; ifa.m1_we = 1'b0; ifa.m1_re = 1'b0; ifa.m1_addr = 30'h0; ifa.m1_wdata = 32'h0;
    ifb.m0_req = 1'b0; ifb.m0_we = 1'b0; ifb.m0_re = 1'b0; ifb.m0_addr = 30'h0; ifb.m0_wdata = 32'h0;
    ifb.m1_req = 1'b0; ifb.m1_we = 1'b0; ifb.m1_re = 1'b0; ifb.m1_addr = 30'h0; ifb.m1_wdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    ifa.p_readData = 32'h0;
    ifb.p_readData = 32'h0;
    #2 rst = 1'b0;
    step();
    step();
    tests_run++;
    if ({ifa.m0_gnt, ifa.m1_gnt, ifa.m0_done, ifa.m1_done, ifa.busy,
         ifa.p_writeEnable, ifa.p_readEnable} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl_a got %b exp 0", {ifa.m0_gnt, ifa.m1_gnt, ifa.m0_done,
               ifa.m1_done, ifa.busy, ifa.p_writeEnable, ifa.p_readEnable});
    end
    tests_run++;
    if ({ifa.rdata, ifa.p_writeData, 2'b00, ifa.p_memAddress} !== 96'h0) begin
      tests_failed++;
      $display("FAIL reset_data_a got %h %h %h exp 0", ifa.rdata, ifa.p_writeData, ifa.p_memAddress);
    end
    tests_run++;
    if ({ifb.m0_gnt, ifb.m1_gnt, ifb.busy, ifb.rdata} !== 35'h0) begin
      tests_failed++;
      $display("FAIL reset_b got %b %b %b %h exp 0", ifb.m0_gnt, ifb.m1_gnt, ifb.busy, ifb.rdata);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    ifa.m0_req = 1'b1; ifa.m0_re = 1'b1; ifa.m0_addr = 30'h10;
    step();
    tests_run++;
    if ({ifa.m0_gnt, ifa.m1_gnt, ifa.p_readEnable, ifa.p_writeEnable, ifa.busy} !== 5'b10101) begin
      tests_failed++;
      $display("FAIL read_issue got %b exp 10101",
               {ifa.m0_gnt, ifa.m1_gnt, ifa.p_readEnable, ifa.p_writeEnable, ifa.busy});
    end
    tests_run++;
    if (ifa.p_memAddress !== 30'h10) begin
      tests_failed++;
      $display("FAIL read_addr got %h exp 10", ifa.p_memAddress);
    end
    ifa.m0_req = 1'b0; ifa.m0_re = 1'b0;
    step();
    tests_run++;
    if ({ifa.m0_gnt, ifa.p_readEnable, ifa.m0_done, ifa.busy} !== 4'b0001 || ifa.p_memAddress !== 30'h10) begin
      tests_failed++;
      $display("FAIL read_resp got %b addr %h exp 0001 addr 10",
               {ifa.m0_gnt, ifa.p_readEnable, ifa.m0_done, ifa.busy}, ifa.p_memAddress);
    end
    step();
    tests_run++;
    if ({ifa.m0_done, ifa.m1_done, ifa.busy} !== 3'b100) begin
      tests_failed++;
      $display("FAIL read_done got %b exp 100", {ifa.m0_done, ifa.m1_done, ifa.busy});
    end
    tests_run++;
    if (ifa.rdata !== 32'h0000_00A5) begin
      tests_failed++;
      $display("FAIL read_rdata got %h exp 000000a5", ifa.rdata);
    end
    step();
    tests_run++;
    if (ifa.m0_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_done_pulse got %b exp 0", ifa.m0_done);
    end
  endtask

  task automatic test_write();
    ifa.m1_req = 1'b1; ifa.m1_we = 1'b1; ifa.m1_re = 1'b1;
    ifa.m1_addr = 30'h20; ifa.m1_wdata = 32'hDEAD_BEEF;
    step();
    tests_run++;
    if ({ifa.m1_gnt, ifa.m0_gnt, ifa.p_writeEnable, ifa.p_readEnable} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL write_issue got %b exp 1010",
               {ifa.m1_gnt, ifa.m0_gnt, ifa.p_writeEnable, ifa.p_readEnable});
    end
    tests_run++;
    if (ifa.p_writeData !== 32'hDEAD_BEEF || ifa.p_memAddress !== 30'h20) begin
      tests_failed++;
      $display("FAIL write_data got %h @%h exp deadbeef @20", ifa.p_writeData, ifa.p_memAddress);
    end
    ifa.m1_req = 1'b0; ifa.m1_we = 1'b0; ifa.m1_re = 1'b0;
    step();
    step();
    tests_run++;
    if ({ifa.m1_done, ifa.m0_done} !== 2'b10) begin
      tests_failed++;
      $display("FAIL write_done got %b exp 10", {ifa.m1_done, ifa.m0_done});
    end
    tests_run++;
    if (ifa.rdata !== 32'h0000_00A5) begin
      tests_failed++;
      $display("FAIL write_rdata_held got %h exp 000000a5", ifa.rdata);
    end
  endtask

  task automatic test_round_robin();
    logic        w;
    logic [29:0] a;
    for (int i = 0; i < 4; i++) begin
      ifa.m0_req = 1'b1; ifa.m0_re = 1'b1; ifa.m0_addr = 30'h100 + 30'(i);
      ifa.m1_req = 1'b1; ifa.m1_re = 1'b1; ifa.m1_addr = 30'h200 + 30'(i);
      w = (i % 2 == 1);
      a = w ? (30'h200 + 30'(i)) : (30'h100 + 30'(i));
      step();
      tests_run++;
      if ({ifa.m0_gnt, ifa.m1_gnt} !== {~w, w}) begin
        tests_failed++;
        $display("FAIL rr_gnt[%0d] got %b exp %b", i, {ifa.m0_gnt, ifa.m1_gnt}, {~w, w});
      end
      ifa.m0_req = 1'b0; ifa.m1_req = 1'b0;
      step();
      step();
      tests_run++;
      if ({ifa.m0_done, ifa.m1_done} !== {~w, w} || ifa.rdata !== periph_resp(a)) begin
        tests_failed++;
        $display("FAIL rr_done[%0d] got %b %h exp %b %h", i, {ifa.m0_done, ifa.m1_done},
                 ifa.rdata, {~w, w}, periph_resp(a));
      end
    end
    ifa.m0_re = 1'b0; ifa.m1_re = 1'b0;
  endtask

  task automatic test_fixed_prio();
    int m1_gnts;
    m1_gnts = 0;
    ifb.m0_req = 1'b1; ifb.m1_req = 1'b1; ifb.m1_we = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      tests_run++;
      if (ifb.m0_gnt !== (c % 3 == 0)) begin
        tests_failed++;
        $display("FAIL fixed_m0_gnt[%0d] got %b exp %b", c, ifb.m0_gnt, (c % 3 == 0));
      end
      if ((c % 3 == 0) && (ifb.p_writeEnable !== 1'b0 || ifb.p_readEnable !== 1'b0)) begin
        tests_failed++;
        $display("FAIL fixed_noop_en[%0d] got %b%b exp 00", c, ifb.p_writeEnable, ifb.p_readEnable);
      end
      if (ifb.m1_gnt === 1'b1) m1_gnts++;
    end
    tests_run++;
    if (m1_gnts !== 0) begin
      tests_failed++;
      $display("FAIL fixed_m1_gnt got %0d exp 0", m1_gnts);
    end
    ifb.m0_req = 1'b0; ifb.m1_req = 1'b0; ifb.m1_we = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset_mid();
    ifa.m1_req = 1'b1; ifa.m1_re = 1'b1; ifa.m1_addr = 30'h33;
    step();
    ifa.m1_req = 1'b0; ifa.m1_re = 1'b0;
    step();
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if ({ifa.m1_gnt, ifa.m1_done, ifa.busy, ifa.p_readEnable, ifa.p_writeEnable} !== 5'b0 ||
        ifa.rdata !== 32'h0 || ifa.p_memAddress !== 30'h0) begin
      tests_failed++;
      $display("FAIL rst_mid got %b %h %h exp 0",
               {ifa.m1_gnt, ifa.m1_done, ifa.busy, ifa.p_readEnable, ifa.p_writeEnable},
               ifa.rdata, ifa.p_memAddress);
    end
    step();
    rst = 1'b1;
    step();
    tests_run++;
    if ({ifa.m1_done, ifa.m0_done, ifa.busy} !== 3'b0) begin
      tests_failed++;
      $display("FAIL rst_no_done got %b exp 000", {ifa.m1_done, ifa.m0_done, ifa.busy});
    end
    ifa.m0_req = 1'b1; ifa.m1_req = 1'b1;
    step();
    tests_run++;
    if ({ifa.m0_gnt, ifa.m1_gnt} !== 2'b10) begin
      tests_failed++;
      $display("FAIL rst_tie got %b exp 10", {ifa.m0_gnt, ifa.m1_gnt});
    end
    ifa.m0_req = 1'b0; ifa.m1_req = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic test_late_request();
    ifa.m0_req = 1'b1; ifa.m0_re = 1'b1; ifa.m0_addr = 30'h44;
    step();
    ifa.m0_req = 1'b0; ifa.m0_re = 1'b0;
    ifa.m1_req = 1'b1; ifa.m1_we = 1'b1; ifa.m1_addr = 30'h55; ifa.m1_wdata = 32'h1234_5678;
    step();
    tests_run++;
    if (ifa.m1_gnt !== 1'b0) begin
      tests_failed++;
      $display("FAIL late_resp_gnt got %b exp 0", ifa.m1_gnt);
    end
    step();
    tests_run++;
    if ({ifa.m0_done, ifa.m1_gnt} !== 2'b10 || ifa.rdata !== periph_resp(30'h44)) begin
      tests_failed++;
      $display("FAIL late_m0_done got %b %h exp 10 %h", {ifa.m0_done, ifa.m1_gnt},
               ifa.rdata, periph_resp(30'h44));
    end
    step();
    tests_run++;
    if ({ifa.m1_gnt, ifa.p_writeEnable} !== 2'b11 || ifa.p_memAddress !== 30'h55 ||
        ifa.p_writeData !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL late_m1_gnt got %b %h %h exp 11 55 12345678", {ifa.m1_gnt, ifa.p_writeEnable},
               ifa.p_memAddress, ifa.p_writeData);
    end
    ifa.m1_req = 1'b0; ifa.m1_we = 1'b0;
    step();
    step();
    tests_run++;
    if (ifa.m1_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL late_m1_done got %b exp 1", ifa.m1_done);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_fixed_prio();
    test_reset_mid();
    test_late_request();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
